iter_muldiv_alu: RTL and testbench

//  Parametrised multi-cycle successor to the combinational integer ALU. Single-cycle
//  ops pass through one register stage. Real MIPS mult/div/madd run as iterative

---
 rtl/iter_muldiv_alu.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_iter_muldiv_alu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_alu.sv
// Iterative integer ALU. Single-cycle ops are registered in one stage. mult/div/madd
// use radix-2 shift-add and restoring division with HI/LO written only on completion.
module iter_muldiv_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             div_by_zero
);

  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_MADD  = 5'b00011;
  localparam logic [4:0] OP_MADDU = 5'b00100;
  localparam logic [4:0] OP_MUL   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_OR    = 5'b00111;
  localparam logic [4:0] OP_NOR   = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_SLT   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_SLL   = 5'b01100;
  localparam logic [4:0] OP_SRL   = 5'b01101;
  localparam logic [4:0] OP_SRA   = 5'b01110;
  localparam logic [4:0] OP_LUI   = 5'b01111;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [4:0]           r_op;
  logic [SHW:0]         r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_overflow;
  logic                 r_carry;
  logic                 r_dbz;
  logic                 r_neg;
  logic                 r_neg_rem;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;

  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_b_zero;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_sc_result;
  logic                 w_sc_ovf;
  logic                 w_sc_carry;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH-1:0]     w_mul_res;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_trial;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_overflow;
  assign carry_out   = r_carry;
  assign div_by_zero = r_dbz;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    case (alu_op)
      OP_MUL, OP_MADD, OP_MULT: begin
        w_is_mul = 1'b1;
        w_signed = 1'b1;
      end
      OP_MADDU, OP_MULTU: w_is_mul = 1'b1;
      OP_DIV: begin
        w_is_div = 1'b1;
        w_signed = 1'b1;
      end
      OP_DIVU: w_is_div = 1'b1;
      default: ;
    endcase
  end

  // Iteration runs on magnitudes; the sign is restored once at completion.
  assign w_b_zero = (b == '0);
  assign w_neg_a  = w_signed & a[WIDTH-1];
  assign w_neg_b  = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -a : a;
  assign w_mag_b  = w_neg_b ? -b : b;

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    w_sc_carry  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_sc_result = w_add[WIDTH-1:0];
        w_sc_carry  = w_add[WIDTH];
        w_sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_result = w_sub[WIDTH-1:0];
        w_sc_carry  = w_sub[WIDTH];
        w_sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_sc_result = a & b;
      OP_OR:   w_sc_result = a | b;
      OP_NOR:  w_sc_result = ~(a | b);
      OP_XOR:  w_sc_result = a ^ b;
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  w_sc_result = b << a[SHW-1:0];
      OP_SRL:  w_sc_result = b >> a[SHW-1:0];
      OP_SRA:  w_sc_result = $signed(b) >>> a[SHW-1:0];
      OP_LUI:  w_sc_result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: w_sc_result = r_hi;
      OP_MFLO: w_sc_result = r_lo;
      default: ;
    endcase
  end

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_acc_sum = {r_hi, r_lo} + w_prod;
  assign w_mul_res = ((r_op == OP_MADD) || (r_op == OP_MADDU)) ? w_acc_sum[WIDTH-1:0]
                                                               : w_prod[WIDTH-1:0];

  // Remainder stays below the divisor, so the trial difference always fits WIDTH bits.
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_divisor};
  assign w_quo       = r_neg ? -r_quo : r_quo;
  assign w_rem       = r_neg_rem ? -r_rem : r_rem;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_mul)                    w_state_next = S_MUL;
          else if (w_is_div && !w_b_zero)  w_state_next = S_DIV;
          else                             w_state_next = S_DONE;
        end
      end
      S_MUL, S_DIV: if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE:       if (out_ready)   w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
      r_dbz      <= 1'b0;
      r_neg      <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= alu_op;
            r_dbz <= 1'b0;
            if (w_is_mul) begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
              r_mplier <= w_mag_b;
              r_neg    <= w_neg_a ^ w_neg_b;
              r_cnt    <= (SHW+1)'(WIDTH);
            end else if (w_is_div && w_b_zero) begin
              r_lo       <= '1;
              r_hi       <= a;
              r_result   <= '1;
              r_zero     <= 1'b0;
              r_overflow <= 1'b0;
              r_carry    <= 1'b0;
              r_dbz      <= 1'b1;
            end else if (w_is_div) begin
              r_rem     <= '0;
              r_quo     <= w_mag_a;
              r_divisor <= w_mag_b;
              r_neg     <= w_neg_a ^ w_neg_b;
              r_neg_rem <= w_neg_a;
              r_cnt     <= (SHW+1)'(WIDTH);
            end else begin
              r_result   <= w_sc_result;
              r_zero     <= (w_sc_result == '0);
              r_overflow <= w_sc_ovf;
              r_carry    <= w_sc_carry;
            end
          end
        end
        S_MUL: begin
          if (r_cnt != '0) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
          end else begin
            if ((r_op == OP_MULT) || (r_op == OP_MULTU)) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if ((r_op == OP_MADD) || (r_op == OP_MADDU)) begin
              r_hi <= w_acc_sum[2*WIDTH-1:WIDTH];
              r_lo <= w_acc_sum[WIDTH-1:0];
            end
            r_result   <= w_mul_res;
            r_zero     <= (w_mul_res == '0);
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
          end
        end
        S_DIV: begin
          if (r_cnt != '0) begin
            if (!w_div_trial[WIDTH]) begin
              r_rem <= w_div_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_div_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_lo       <= w_quo;
            r_hi       <= w_rem;
            r_result   <= w_quo;
            r_zero     <= (w_quo == '0);
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Directed and random checks of iter_muldiv_alu against an arithmetic reference
// model of HI/LO and the per-op results.
module tb_iter_muldiv_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic        div_by_zero;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  iter_muldiv_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; lat counts clock edges after the accept edge.
  task automatic model(input logic [4:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] r, output logic ov, output logic cy,
                       output logic dz, output int lat);
    longint      sa, sb, s, q, rm;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = {32'h0, xa};
    ub = {32'h0, xb};
    r = '0; ov = 1'b0; cy = 1'b0; dz = 1'b0; lat = 0;
    case (op)
      5'b00001: begin s = sa + sb; r = xa + xb; ov = (s > SMAX) || (s < SMIN); cy = (ua + ub) > 64'hFFFF_FFFF; end
      5'b00010: begin s = sa - sb; r = xa - xb; ov = (s > SMAX) || (s < SMIN); cy = (xa < xb); end
      5'b00110: r = xa & xb;
      5'b00111: r = xa | xb;
      5'b01000: r = ~(xa | xb);
      5'b01001: r = xa ^ xb;
      5'b01010: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b01011: r = (xa < xb) ? 32'd1 : 32'd0;
      5'b01100: r = xb << (xa % 32);
      5'b01101: r = xb >> (xa % 32);
      5'b01110: begin p = sb >>> (xa % 32); r = p[31:0]; end
      5'b01111: r = xb << 16;
      5'b10100: r = m_hi;
      5'b10101: r = m_lo;
      5'b00101: begin p = sa * sb; r = p[31:0]; lat = 33; end
      5'b10000: begin p = sa * sb; {m_hi, m_lo} = p; r = m_lo; lat = 33; end
      5'b10001: begin p = ua * ub; {m_hi, m_lo} = p; r = m_lo; lat = 33; end
      5'b00011: begin p = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = p; r = m_lo; lat = 33; end
      5'b00100: begin p = {m_hi, m_lo} + ua * ub; {m_hi, m_lo} = p; r = m_lo; lat = 33; end
      5'b10010, 5'b10011: begin
        if (xb == 32'h0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = xa; dz = 1'b1;
        end else begin
          if (op == 5'b10010) begin q = sa / sb; rm = sa % sb; end
          else                begin q = longint'(ua / ub); rm = longint'(ua % ub); end
          m_lo = 32'(q); m_hi = 32'(rm); lat = 33;
        end
        r = m_lo;
      end
      default: r = '0;
    endcase
  endtask

  task automatic start(input logic [4:0] op, input logic [31:0] xa, input logic [31:0] xb);
    alu_op = op; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] xa, input logic [31:0] xb,
                        input string tag, input int hold);
    logic [31:0] er;
    logic        eov, ecy, edz;
    int          elat, lat;
    model(op, xa, xb, er, eov, ecy, edz, elat);
    start(op, xa, xb);
    wait_done(lat);
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, zero, (er == 32'h0));
    chk({tag, ".ovf"}, overflow, eov);
    chk({tag, ".carry"}, carry_out, ecy);
    chk({tag, ".dbz"}, div_by_zero, edz);
    $display("[TB] %s op=%b a=%h b=%h result=%h lat=%0d", tag, op, xa, xb, result, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid, 1'b1);
      chk({tag, ".hold_result"}, result, er);
    end
    release_out();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n_valid_seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset.in_ready", in_ready, 1'b1);
    chk("reset.out_valid", out_valid, 1'b0);
    chk("reset.result", result, 32'h0);
    chk("reset.flags", {zero, overflow, carry_out, div_by_zero}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    run_op(5'b10100, 0, 0, "reset.hi", 0);
    run_op(5'b10101, 0, 0, "reset.lo", 0);

    run_op(5'b00001, 32'h7FFF_FFFF, 32'h1, "t1.add", 0);
    chk("t1.result_const", result, 32'h8000_0000);
    chk("t1.ovf_const", overflow, 1'b1);

    run_op(5'b10000, 32'hFFFF_FFFE, 32'h3, "t2.mult", 0);
    run_op(5'b10100, 0, 0, "t2.mfhi", 0);
    chk("t2.hi_const", result, 32'hFFFF_FFFF);
    run_op(5'b10101, 0, 0, "t2.mflo", 0);
    chk("t2.lo_const", result, 32'hFFFF_FFFA);

    run_op(5'b10000, 32'h2, 32'h3, "t3.mult", 0);
    run_op(5'b00011, 32'h4, 32'h5, "t3.madd", 0);
    chk("t3.lo_const", result, 32'h0000_001A);
    run_op(5'b10100, 0, 0, "t3.mfhi", 5);
    chk("t3.hi_const", result, 32'h0);

    run_op(5'b10010, 32'hFFFF_FFF9, 32'h2, "t4.div", 0);
    chk("t4.lo_const", result, 32'hFFFF_FFFD);
    run_op(5'b10100, 0, 0, "t4.mfhi", 0);
    chk("t4.hi_const", result, 32'hFFFF_FFFF);
    run_op(5'b10011, 32'h7, 32'h0, "t4.divu0", 0);
    chk("t4.dbz_const", div_by_zero, 1'b1);
    run_op(5'b10100, 0, 0, "t4.divu0_hi", 0);
    run_op(5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, "t4.minneg", 0);
    run_op(5'b10100, 0, 0, "t4.minneg_hi", 0);

    start(5'b10001, 32'h0001_2345, 32'h0000_6789);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("t5.flush_valid", out_valid, 1'b0);
    chk("t5.flush_ready", in_ready, 1'b1);
    n_valid_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) n_valid_seen++;
    end
    chk("t5.no_valid", 64'(n_valid_seen), 64'd0);
    run_op(5'b10100, 0, 0, "t5.mfhi", 0);
    run_op(5'b10101, 0, 0, "t5.mflo", 0);

    run_op(5'b00111, 32'h5500, 32'h0055, "t5.or", 0);
    start(5'b10000, 32'h3, 32'h5);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5.rst_result", result, 32'h0);
    chk("t5.rst_valid", out_valid, 1'b0);
    chk("t5.rst_ready", in_ready, 1'b1);
    chk("t5.rst_flags", {zero, overflow, carry_out, div_by_zero}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    run_op(5'b10100, 0, 0, "t5.rst_hi", 0);
    run_op(5'b10101, 0, 0, "t5.rst_lo", 0);

    run_op(5'b01110, 32'h4, 32'h8000_0000, "t6.sra", 0);
    chk("t6.sra_const", result, 32'hF800_0000);
    run_op(5'b01100, 32'd33, 32'h1, "t6.sll", 0);
    chk("t6.sll_const", result, 32'h2);
    run_op(5'b01111, 32'h0, 32'h1234, "t6.lui", 0);
    chk("t6.lui_const", result, 32'h1234_0000);

    for (int i = 0; i < 80; i++) begin
      logic [4:0] rop;
      rop = 5'($urandom_range(0, 31));
      run_op(rop, rnd_operand(), rnd_operand(), "rand", 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
